execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter ADRS_W, default 11, memory/branch address width.
REQ-003 Parameter MEM_TIMEOUT, default 15, max cycles waiting for mem_ack.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decode stage presents an instruction.
REQ-007 in_ready  out  1  stage accepts instruction this cycle.
REQ-008 in_opcode  in  3  LOAD 111, STORE 110, BRANCH 101, ADD 100, SUBTRACT 011, AND 010, OR 001, NOOP 000.
REQ-009 in_src_type  in  1  0 register source, 1 immediate (informational, passed to out_src_type).
REQ-010 in_dest_type  in  1  0 register destination, 1 memory destination.
REQ-011 in_src_val  in  DATA_W  source operand (register value or immediate, already resolved).
REQ-012 in_dst_val  in  DATA_W  destination operand value.
REQ-013 in_adrs  in  ADRS_W  memory address or branch target.
REQ-014 mem_req / mem_we  out  1 / 1  memory request, write enable.
REQ-015 mem_adrs / mem_wdata  out  ADRS_W / DATA_W  request address, write data.
REQ-016 mem_ack / mem_rdata  in  1 / DATA_W  completion, read data.
REQ-017 out_valid / out_ready  out / in  1 / 1  result handshake to writeback.
REQ-018 result  out  DATA_W  executed result; carry  out  1  carry/borrow flag.
REQ-019 wb_adrs  out  ADRS_W  writeback address; out_dest_type, out_src_type  out  1 each.
REQ-020 branch_valid  out  1  one-cycle pulse, branch taken; branch_address  out  ADRS_W  target.
REQ-021 mem_err  out  1  sticky with out_valid, memory timeout occurred.

Function
REQ-022 FSM states: IDLE, MEM, HOLD; in_ready = 1 only in IDLE.
REQ-023 Transfer occurs when in_valid & in_ready; inputs captured in the same edge.
REQ-024 ADD: result = dst+src (DATA_W), carry = bit DATA_W of the DATA_W+1 sum.
REQ-025 SUBTRACT: result = dst-src, carry = 1 when dst < src unsigned (borrow).
REQ-026 AND/OR: bitwise dst op src; carry cleared to 0.
REQ-027 Internal zero flag Z updated by ADD/SUB/AND/OR to (result==0); unchanged by other opcodes.
REQ-028 ALU opcodes: IDLE -> HOLD, out_valid asserted the cycle after transfer (latency 1).
REQ-029 NOOP: IDLE -> HOLD, result, carry unchanged, out_valid asserted one cycle after transfer.
REQ-030 BRANCH: taken iff Z=1 at transfer; branch_valid pulses one cycle after transfer with branch_address=in_adrs; stays IDLE, no out_valid.
REQ-031 LOAD/STORE: IDLE -> MEM; mem_req asserted from cycle after transfer until mem_ack sampled high; mem_adrs=in_adrs; STORE drives mem_we=1, mem_wdata=in_src_val.
REQ-032 MEM -> HOLD on mem_ack; LOAD result=mem_rdata; STORE result=in_src_val; carry unchanged.
REQ-033 No mem_ack within MEM_TIMEOUT cycles of mem_req: drop mem_req, go HOLD with mem_err=1, result=0.
REQ-034 HOLD: out_valid=1, outputs stable until out_ready; on out_valid&out_ready -> IDLE, out_valid and mem_err clear next cycle.
REQ-035 wb_adrs = in_adrs for all opcodes producing out_valid.
REQ-036 mem_ack outside MEM is ignored.
REQ-037 in_valid while not ready: no capture; decode holds its inputs.

Reset
REQ-038 On reset low: state IDLE, out_valid 0, mem_req 0, mem_we 0, branch_valid 0, mem_err 0, result 0, carry 0, Z 0, addresses 0.
REQ-039 Reset mid-MEM aborts the transaction: mem_req drops asynchronously, no result produced.
REQ-040 First transfer possible the first rising edge after reset deasserts.

Structure
REQ-041 Opcode localparams, FSM state encoding and widths live in shared package cpu_pkg.
REQ-042 ALU arithmetic in sub-module alu (combinational: opcode, operands -> result, carry, zero); FSM and registers in execute_stage.

Verification
REQ-043 ADD dst=0xFFFFFFFF src=1 -> next cycle out_valid, result=0, carry=1; following BRANCH adrs=0x040 -> branch_valid pulse, branch_address=0x040.
REQ-044 SUBTRACT dst=5 src=7 -> result=0xFFFFFFFE, carry=1; then BRANCH -> no branch_valid (Z=0).
REQ-045 LOAD adrs=0x123, mem_ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles, then out_valid, result=0xDEADBEEF, wb_adrs=0x123.
REQ-046 STORE src=0xA5, no mem_ack -> mem_req dropped after 15 cycles, out_valid with mem_err=1.
REQ-047 ALU result with out_ready=0 for 4 cycles -> result/out_valid stable, in_ready=0, second instruction accepted only after handshake.
REQ-048 Reset asserted during MEM -> mem_req=0 immediately, state IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the execute stage.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_NOOP   = 3'b000;
  localparam logic [OPC_W-1:0] OP_OR     = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND    = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB    = 3'b011;
  localparam logic [OPC_W-1:0] OP_ADD    = 3'b100;
  localparam logic [OPC_W-1:0] OP_BRANCH = 3'b101;
  localparam logic [OPC_W-1:0] OP_STORE  = 3'b110;
  localparam logic [OPC_W-1:0] OP_LOAD   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // LOAD and STORE are the only opcodes that go through the memory port.
  function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Opcodes that produce a new result/carry/zero from the ALU.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB with carry/borrow, bitwise AND/OR, zero detect.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] dst_val,
  input  logic [DATA_W-1:0] src_val,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extended-width add/sub so the top bit is carry out / borrow out.
  always_comb begin
    sum    = {1'b0, dst_val} + {1'b0, src_val};
    diff   = {1'b0, dst_val} - {1'b0, src_val};
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = dst_val & src_val;
      OP_OR:   result = dst_val | src_val;
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU ops, branch resolution on the zero flag, and a
// single-outstanding memory port with timeout, handing results to writeback.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADRS_W      = 11,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic              in_src_type,
  input  logic              in_dest_type,
  input  logic [DATA_W-1:0] in_src_val,
  input  logic [DATA_W-1:0] in_dst_val,
  input  logic [ADRS_W-1:0] in_adrs,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic [ADRS_W-1:0] wb_adrs,
  output logic              out_dest_type,
  output logic              out_src_type,
  output logic              branch_valid,
  output logic [ADRS_W-1:0] branch_address,
  output logic              mem_err
);

  // Counter holds 0..MEM_TIMEOUT-1; the last value is the final mem_req cycle.
  localparam int TCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  state_t state_p1;
  state_t state_d;

  logic              xfer;
  logic              tmo_last;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  logic [DATA_W-1:0] result_p1;
  logic              carry_p1;
  logic              zero_p1;
  logic [ADRS_W-1:0] wb_adrs_p1;
  logic              dest_type_p1;
  logic              src_type_p1;
  logic [ADRS_W-1:0] mem_adrs_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic              mem_we_p1;
  logic              is_load_p1;
  logic              branch_valid_p1;
  logic [ADRS_W-1:0] branch_adrs_p1;
  logic              mem_err_p1;
  logic [TCNT_W-1:0] tmo_cnt_p1;

  assign xfer     = in_valid & in_ready;
  assign tmo_last = (tmo_cnt_p1 == TCNT_LAST);

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode  (in_opcode),
    .dst_val (in_dst_val),
    .src_val (in_src_val),
    .result  (alu_result),
    .carry   (alu_carry),
    .zero    (alu_zero)
  );

  // FSM state register; reset returns to IDLE, which drops mem_req at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_p1 <= ST_IDLE;
    else        state_p1 <= state_d;
  end

  // Next-state: branches resolve in IDLE, memory ops wait in MEM, results wait in HOLD.
  always_comb begin
    state_d = state_p1;
    case (state_p1)
      ST_IDLE: begin
        if (xfer) begin
          if (is_mem_op(in_opcode))      state_d = ST_MEM;
          else if (in_opcode != OP_BRANCH) state_d = ST_HOLD;
        end
      end
      ST_MEM:  if (mem_ack || tmo_last) state_d = ST_HOLD;
      ST_HOLD: if (out_ready)           state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    in_ready  = (state_p1 == ST_IDLE);
    out_valid = (state_p1 == ST_HOLD);
    mem_req   = (state_p1 == ST_MEM);
    mem_we    = mem_req & mem_we_p1;
  end

  // Capture on transfer, complete memory accesses, and clear the error on handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_p1       <= '0;
      carry_p1        <= 1'b0;
      zero_p1         <= 1'b0;
      wb_adrs_p1      <= '0;
      dest_type_p1    <= 1'b0;
      src_type_p1     <= 1'b0;
      mem_adrs_p1     <= '0;
      mem_wdata_p1    <= '0;
      mem_we_p1       <= 1'b0;
      is_load_p1      <= 1'b0;
      branch_valid_p1 <= 1'b0;
      branch_adrs_p1  <= '0;
      mem_err_p1      <= 1'b0;
      tmo_cnt_p1      <= '0;
    end else begin
      branch_valid_p1 <= 1'b0;
      if (xfer) begin
        if (in_opcode == OP_BRANCH) begin
          if (zero_p1) begin
            branch_valid_p1 <= 1'b1;
            branch_adrs_p1  <= in_adrs;
          end
        end else begin
          wb_adrs_p1   <= in_adrs;
          dest_type_p1 <= in_dest_type;
          src_type_p1  <= in_src_type;
          if (is_mem_op(in_opcode)) begin
            mem_adrs_p1  <= in_adrs;
            mem_wdata_p1 <= in_src_val;
            mem_we_p1    <= (in_opcode == OP_STORE);
            is_load_p1   <= (in_opcode == OP_LOAD);
            tmo_cnt_p1   <= '0;
          end else if (is_alu_op(in_opcode)) begin
            result_p1 <= alu_result;
            carry_p1  <= alu_carry;
            zero_p1   <= alu_zero;
          end
        end
      end
      if (state_p1 == ST_MEM) begin
        if (mem_ack) begin
          result_p1 <= is_load_p1 ? mem_rdata : mem_wdata_p1;
          mem_we_p1 <= 1'b0;
        end else if (tmo_last) begin
          result_p1  <= '0;
          mem_err_p1 <= 1'b1;
          mem_we_p1  <= 1'b0;
        end else begin
          tmo_cnt_p1 <= tmo_cnt_p1 + 1'b1;
        end
      end
      if ((state_p1 == ST_HOLD) && out_ready) mem_err_p1 <= 1'b0;
    end
  end

  assign result         = result_p1;
  assign carry          = carry_p1;
  assign wb_adrs        = wb_adrs_p1;
  assign out_dest_type  = dest_type_p1;
  assign out_src_type   = src_type_p1;
  assign mem_adrs       = mem_adrs_p1;
  assign mem_wdata      = mem_wdata_p1;
  assign branch_valid   = branch_valid_p1;
  assign branch_address = branch_adrs_p1;
  assign mem_err        = mem_err_p1;

endmodule
